// File: rtl/data_controller.sv
// -----------------------------------------------------------------------------
// data_controller
//   Feature-map tile fetcher for the Winograd convolution datapath. Walks the
//   block grid commanded by the main controller in raster order, reads each
//   input tile row by row from the feature SRAM, and presents the assembled
//   tile to the PE array over a valid/ready handshake. A one-cycle
//   loop_finished_o pulse marks the end of the pass.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   block_width_i     blocks per row    (0 is treated as 1)
//   block_height_i    blocks per column (0 is treated as 1)
//   data_id_i         input-channel index for the pass
//   data_prepare_i    level; high requests a pass
//   loop_finished_o   one-cycle pulse, pass complete
//   rd_en_o           SRAM read strobe
//   rd_addr_o         {id[3:0], by[7:0], bx[7:0], row[2:0]}
//   rd_data_i         one tile row, valid RD_LAT cycles after rd_en_o
//   tile_valid_o      tile presented to the PE array
//   tile_ready_i      PE array accepts the tile
//   tile_data_o       tile, row r at [r*TILE_ROWS*DATA_W +: TILE_ROWS*DATA_W]
//   tile_bx_o/by_o    block coordinates of the presented tile
//   tile_last_o       presented tile is the last one of the pass
// -----------------------------------------------------------------------------
module data_controller #(
  parameter int DATA_W    = 8,
  parameter int TILE_ROWS = 6,
  parameter int RD_LAT    = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [7:0]                            block_width_i,
  input  logic [7:0]                            block_height_i,
  input  logic [3:0]                            data_id_i,
  input  logic                                  data_prepare_i,
  output logic                                  loop_finished_o,
  output logic                                  rd_en_o,
  output logic [22:0]                           rd_addr_o,
  input  logic [TILE_ROWS*DATA_W-1:0]           rd_data_i,
  output logic                                  tile_valid_o,
  input  logic                                  tile_ready_i,
  output logic [TILE_ROWS*TILE_ROWS*DATA_W-1:0] tile_data_o,
  output logic [7:0]                            tile_bx_o,
  output logic [7:0]                            tile_by_o,
  output logic                                  tile_last_o
);

  localparam int         ROW_W    = TILE_ROWS * DATA_W;
  localparam logic [2:0] LAST_ROW = 3'(TILE_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_TILE, S_DONE, S_RELEASE
  } state_t;

  state_t r_state, w_next;

  logic [7:0]                            r_width, r_height, r_bx, r_by;
  logic [3:0]                            r_id;
  logic [2:0]                            r_row;
  logic [TILE_ROWS*TILE_ROWS*DATA_W-1:0] r_tile;
  logic                                  r_cap_vld [RD_LAT];
  logic [2:0]                            r_cap_row [RD_LAT];

  logic w_rd_en, w_tile_valid, w_finished;
  logic w_last_tile, w_cap_fire, w_bx_end;
  logic [2:0] w_cap_row;

  assign w_bx_end    = (r_bx == r_width - 8'd1);
  assign w_last_tile = w_bx_end && (r_by == r_height - 8'd1);
  assign w_cap_fire  = r_cap_vld[RD_LAT-1];
  assign w_cap_row   = r_cap_row[RD_LAT-1];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    w_rd_en      = 1'b0;
    w_tile_valid = 1'b0;
    w_finished   = 1'b0;
    case (r_state)
      S_IDLE:    if (data_prepare_i) w_next = S_FETCH;
      S_FETCH: begin
        w_rd_en = 1'b1;
        if (r_row == LAST_ROW) w_next = S_DRAIN;
      end
      // Leave once the final row has landed in the tile register.
      S_DRAIN:   if (w_cap_fire && w_cap_row == LAST_ROW) w_next = S_TILE;
      S_TILE: begin
        w_tile_valid = 1'b1;
        if (tile_ready_i) w_next = w_last_tile ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_finished = 1'b1;
        w_next     = S_RELEASE;
      end
      // A pass only restarts after prepare has been seen low once.
      S_RELEASE: if (!data_prepare_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: state and counters use non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_width  <= '0;
      r_height <= '0;
      r_id     <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_row    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (data_prepare_i) begin
          r_width  <= (block_width_i  == 8'd0) ? 8'd1 : block_width_i;
          r_height <= (block_height_i == 8'd0) ? 8'd1 : block_height_i;
          r_id     <= data_id_i;
          r_bx     <= '0;
          r_by     <= '0;
          r_row    <= '0;
        end
        S_FETCH: r_row <= (r_row == LAST_ROW) ? 3'd0 : r_row + 3'd1;
        S_TILE: if (tile_ready_i && !w_last_tile) begin
          if (w_bx_end) begin
            r_bx <= '0;
            r_by <= r_by + 8'd1;
          end else begin
            r_bx <= r_bx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read strobe and row index travel together so the returning data knows
  // which tile row it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_cap_vld[i] <= 1'b0;
        r_cap_row[i] <= '0;
      end
    end else begin
      r_cap_vld[0] <= w_rd_en;
      r_cap_row[0] <= r_row;
      for (int i = 1; i < RD_LAT; i++) begin
        r_cap_vld[i] <= r_cap_vld[i-1];
        r_cap_row[i] <= r_cap_row[i-1];
      end
    end
  end

  // NOTE: the tile register is a wide storage element that normally would not
  // need a reset, but its contents are visible on tile_data_o and must read
  // zero after reset, so it is cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tile <= '0;
    end else begin
      for (int r = 0; r < TILE_ROWS; r++)
        if (w_cap_fire && w_cap_row == 3'(r))
          r_tile[r*ROW_W +: ROW_W] <= rd_data_i;
    end
  end

  assign loop_finished_o = w_finished;
  assign rd_en_o         = w_rd_en;
  assign rd_addr_o       = w_rd_en ? {r_id, r_by, r_bx, r_row} : 23'd0;
  assign tile_valid_o    = w_tile_valid;
  assign tile_data_o     = r_tile;
  assign tile_bx_o       = r_bx;
  assign tile_by_o       = r_by;
  assign tile_last_o     = w_tile_valid & w_last_tile;

endmodule

// File: tb/tb_data_controller.sv
// -----------------------------------------------------------------------------
// tb_data_controller
//   Self-checking bench for data_controller. A default instance (RD_LAT=1)
//   covers the main scenarios; a second instance with RD_LAT=3 covers the
//   zero-size / longer-latency case. The SRAM is a hash of the read address,
//   and expected reads and tiles are derived from the raster walk of the grid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_controller;

  localparam int ROW_W = 48;
  localparam int TD    = 288;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     block_width_i, block_height_i;
  logic [3:0]     data_id_i;
  logic           data_prepare_i, prepare3;
  logic           tile_ready_i;
  logic [ROW_W-1:0] rd_data_i, rd_data3;

  logic           loop_finished_o, rd_en_o, tile_valid_o, tile_last_o;
  logic [22:0]    rd_addr_o;
  logic [TD-1:0]  tile_data_o;
  logic [7:0]     tile_bx_o, tile_by_o;

  logic           fin3, rd_en3, valid3, last3;
  logic [22:0]    rd_addr3;
  logic [TD-1:0]  tile_data3;
  logic [7:0]     bx3, by3;

  int             checks = 0;
  int             errors = 0;
  logic [31:0]    seed;

  always #5 clk = ~clk;

  data_controller u_dut (
    .clk(clk), .reset(reset),
    .block_width_i(block_width_i), .block_height_i(block_height_i),
    .data_id_i(data_id_i), .data_prepare_i(data_prepare_i),
    .loop_finished_o(loop_finished_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_data_o(tile_data_o), .tile_bx_o(tile_bx_o), .tile_by_o(tile_by_o),
    .tile_last_o(tile_last_o)
  );

  data_controller #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .block_width_i(block_width_i), .block_height_i(block_height_i),
    .data_id_i(data_id_i), .data_prepare_i(prepare3),
    .loop_finished_o(fin3), .rd_en_o(rd_en3), .rd_addr_o(rd_addr3),
    .rd_data_i(rd_data3), .tile_valid_o(valid3), .tile_ready_i(tile_ready_i),
    .tile_data_o(tile_data3), .tile_bx_o(bx3), .tile_by_o(by3),
    .tile_last_o(last3)
  );

  // SRAM contents: a deterministic hash of the address.
  function automatic logic [ROW_W-1:0] mem_row(input logic [22:0] a, input logic [31:0] s);
    logic [31:0]      x;
    logic [ROW_W-1:0] res;
    x = {9'd0, a} ^ s;
    for (int k = 0; k < 6; k++) begin
      x = x * 32'd1103515245 + 32'd12345;
      res[k*8 +: 8] = x[23:16];
    end
    return res;
  endfunction

  logic [22:0] a1_q, b1_q, b2_q, b3_q;
  always @(posedge clk) begin
    a1_q <= rd_addr_o;
    b1_q <= rd_addr3;
    b2_q <= b1_q;
    b3_q <= b2_q;
  end
  assign rd_data_i = mem_row(a1_q, seed);
  assign rd_data3  = mem_row(b3_q, seed);

  // One full pass on the default instance. Starts with the DUT idle; ends at
  // the cycle after the finished pulse.
  task automatic do_pass(input int w, input int h, input logic [3:0] id,
                         input int smin, input int smax, input bit hold_prep);
    int ew, eh, stalls;
    bit last;
    logic [22:0]   a;
    logic [TD-1:0] et;
    ew = (w == 0) ? 1 : w;
    eh = (h == 0) ? 1 : h;
    @(negedge clk);
    reset          = 1'b1;
    block_width_i  = 8'(w);
    block_height_i = 8'(h);
    data_id_i      = id;
    data_prepare_i = 1'b1;
    for (int by = 0; by < eh; by++) begin
      for (int bx = 0; bx < ew; bx++) begin
        et = '0;
        for (int r = 0; r < 6; r++) begin
          @(negedge clk);
          a = {id, 8'(by), 8'(bx), 3'(r)};
          et[r*ROW_W +: ROW_W] = mem_row(a, seed);
          checks++;
          if ({rd_en_o, rd_addr_o, tile_valid_o, loop_finished_o} !== {1'b1, a, 2'b00}) begin
            errors++;
            $display("FAIL read (%0d,%0d) row %0d: got en=%b addr=%h valid=%b fin=%b, expected en=1 addr=%h valid=0 fin=0",
                     bx, by, r, rd_en_o, rd_addr_o, tile_valid_o, loop_finished_o, a);
          end
          // Command inputs change mid-pass; the DUT must ignore them.
          block_width_i  = 8'($urandom);
          block_height_i = 8'($urandom);
          data_id_i      = 4'($urandom);
          data_prepare_i = 1'($urandom);
          tile_ready_i   = 1'($urandom);
        end
        stalls = $urandom_range(smax, smin);
        last   = (bx == ew - 1) && (by == eh - 1);
        @(negedge clk);
        checks++;
        if ({rd_en_o, tile_valid_o, loop_finished_o} !== 3'b000) begin
          errors++;
          $display("FAIL drain (%0d,%0d): got en=%b valid=%b fin=%b, expected all 0",
                   bx, by, rd_en_o, tile_valid_o, loop_finished_o);
        end
        tile_ready_i = (stalls == 0);
        for (int s = 0; s <= stalls; s++) begin
          @(negedge clk);
          checks++;
          if ({rd_en_o, tile_valid_o, loop_finished_o, tile_last_o, tile_bx_o, tile_by_o, tile_data_o}
              !== {1'b0, 1'b1, 1'b0, last, 8'(bx), 8'(by), et}) begin
            errors++;
            $display("FAIL tile (%0d,%0d) cyc %0d: got en=%b v=%b fin=%b last=%b bx=%0d by=%0d data=%h, expected en=0 v=1 fin=0 last=%b data=%h",
                     bx, by, s, rd_en_o, tile_valid_o, loop_finished_o, tile_last_o,
                     tile_bx_o, tile_by_o, tile_data_o, last, et);
          end
          tile_ready_i = (s == stalls);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({loop_finished_o, tile_valid_o, rd_en_o} !== 3'b100) begin
      errors++;
      $display("FAIL finish pulse: got fin=%b valid=%b en=%b, expected fin=1 valid=0 en=0",
               loop_finished_o, tile_valid_o, rd_en_o);
    end
    tile_ready_i   = 1'b0;
    data_prepare_i = hold_prep;
    @(negedge clk);
    checks++;
    if ({loop_finished_o, tile_valid_o, rd_en_o} !== 3'b000) begin
      errors++;
      $display("FAIL after finish: got fin=%b valid=%b en=%b, expected all 0",
               loop_finished_o, tile_valid_o, rd_en_o);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    data_prepare_i = 1'b1;
    prepare3       = 1'b1;
    block_width_i  = 8'($urandom);
    block_height_i = 8'($urandom);
    data_id_i      = 4'($urandom);
    tile_ready_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        data_prepare_i = 1'b0;
        prepare3       = 1'b0;
        reset          = 1'b1;
      end
      checks++;
      if ({loop_finished_o, rd_en_o, rd_addr_o, tile_valid_o, tile_data_o, tile_bx_o, tile_by_o, tile_last_o,
           fin3, rd_en3, rd_addr3, valid3, tile_data3, bx3, by3, last3} !== '0) begin
        errors++;
        $display("FAIL reset outputs %0d: got fin=%b en=%b addr=%h v=%b bx=%0d by=%0d last=%b data=%h, expected all 0",
                 i, loop_finished_o, rd_en_o, rd_addr_o, tile_valid_o, tile_bx_o, tile_by_o, tile_last_o, tile_data_o);
      end
    end
    @(negedge clk);
    checks++;
    if ({rd_en_o, tile_valid_o, loop_finished_o, rd_en3, valid3} !== 5'b0) begin
      errors++;
      $display("FAIL idle after reset: got en=%b valid=%b fin=%b, expected all 0",
               rd_en_o, tile_valid_o, loop_finished_o);
    end
  endtask

  task automatic test_single_block();
    do_pass(1, 1, 4'd3, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Starts on the cycle the main controller re-raises prepare.
    do_pass(1, 2, 4'd4, 0, 1, 1'b0);
  endtask

  task automatic test_raster();
    do_pass(2, 3, 4'($urandom), 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_pass(2, 1, 4'($urandom), 5, 5, 1'b0);
  endtask

  task automatic test_hold_prepare();
    do_pass(1, 1, 4'd9, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rd_en_o, tile_valid_o, loop_finished_o} !== 3'b000) begin
        errors++;
        $display("FAIL hold prepare %0d: got en=%b valid=%b fin=%b, expected all 0",
                 i, rd_en_o, tile_valid_o, loop_finished_o);
      end
    end
    data_prepare_i = 1'b0;
    do_pass(2, 1, 4'd10, 0, 2, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    block_width_i  = 8'd2;
    block_height_i = 8'd2;
    data_id_i      = 4'd5;
    data_prepare_i = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      checks++;
      if ({rd_en_o, rd_addr_o} !== {1'b1, 4'd5, 16'd0, 3'(r)}) begin
        errors++;
        $display("FAIL pre-reset read row %0d: got en=%b addr=%h, expected en=1 addr=%h",
                 r, rd_en_o, rd_addr_o, {4'd5, 16'd0, 3'(r)});
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({loop_finished_o, rd_en_o, rd_addr_o, tile_valid_o, tile_data_o, tile_bx_o, tile_by_o, tile_last_o} !== '0) begin
      errors++;
      $display("FAIL mid-fetch reset: got fin=%b en=%b addr=%h v=%b bx=%0d by=%0d data=%h, expected all 0",
               loop_finished_o, rd_en_o, rd_addr_o, tile_valid_o, tile_bx_o, tile_by_o, tile_data_o);
    end
    do_pass(2, 2, 4'd5, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++)
      do_pass($urandom_range(3, 0), $urandom_range(3, 0), 4'($urandom), 0, 3, 1'b0);
  endtask

  task automatic test_zero_size_lat3();
    logic [3:0]    id;
    logic [22:0]   a;
    logic [TD-1:0] et;
    id = 4'($urandom);
    et = '0;
    @(negedge clk);
    block_width_i  = 8'd0;
    block_height_i = 8'd0;
    data_id_i      = id;
    prepare3       = 1'b1;
    tile_ready_i   = 1'b0;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      a = {id, 16'd0, 3'(r)};
      et[r*ROW_W +: ROW_W] = mem_row(a, seed);
      checks++;
      if ({rd_en3, rd_addr3, valid3} !== {1'b1, a, 1'b0}) begin
        errors++;
        $display("FAIL lat3 read row %0d: got en=%b addr=%h valid=%b, expected en=1 addr=%h valid=0",
                 r, rd_en3, rd_addr3, valid3, a);
      end
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      checks++;
      if ({rd_en3, valid3, fin3} !== 3'b000) begin
        errors++;
        $display("FAIL lat3 drain %0d: got en=%b valid=%b fin=%b, expected all 0", d, rd_en3, valid3, fin3);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid3, last3, bx3, by3, tile_data3} !== {1'b1, 1'b1, 16'd0, et}) begin
      errors++;
      $display("FAIL lat3 tile: got v=%b last=%b bx=%0d by=%0d data=%h, expected v=1 last=1 bx=0 by=0 data=%h",
               valid3, last3, bx3, by3, tile_data3, et);
    end
    tile_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({fin3, valid3} !== 2'b10) begin
      errors++;
      $display("FAIL lat3 finish: got fin=%b valid=%b, expected fin=1 valid=0", fin3, valid3);
    end
    prepare3     = 1'b0;
    tile_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (fin3 !== 1'b0) begin
      errors++;
      $display("FAIL lat3 pulse width: got fin=%b, expected 0", fin3);
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_raster();
    test_backpressure();
    test_hold_prepare();
    test_reset_mid_fetch();
    test_random();
    test_zero_size_lat3();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_controller.md
# data_controller

Feature-map tile fetcher for the Winograd convolution datapath. It sits directly downstream of the main controller. It takes that controller's per-pass command (block grid size, input-channel index, prepare level) and walks the block grid in raster order. For each block it reads one input tile row by row from the input feature SRAM and hands the assembled tile to the Winograd PE array over a valid/ready handshake. When the whole grid has been delivered it returns a one-cycle `loop_finished_o` pulse to the main controller.

## Interface
Parameters:
- `DATA_W`, 8: bits per feature element.
- `TILE_ROWS`, 6: rows (and columns) per input tile; 6 for F(4,3).
- `RD_LAT`, 1: SRAM read latency in cycles, 1..4.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  reset; one clock; reset is synchronous and active-low.
- `block_width_i`  in  8  blocks per row, from main controller.
- `block_height_i`  in  8  blocks per column, from main controller.
- `data_id_i`  in  4  input-channel index for this pass.
- `data_prepare_i`  in  1  level; high requests a pass.
- `loop_finished_o`  out  1  one-cycle pulse; the pass is complete.
- `rd_en_o`  out  1  SRAM read strobe.
- `rd_addr_o`  out  23  read address `{id[3:0], by[7:0], bx[7:0], row[2:0]}`.
- `rd_data_i`  in  TILE_ROWS*DATA_W  row data, valid RD_LAT cycles after `rd_en_o`.
- `tile_valid_o`  out  1  tile available to the PE array.
- `tile_ready_i`  in  1  PE array accepts the tile.
- `tile_data_o`  out  TILE_ROWS*TILE_ROWS*DATA_W  tile; row r occupies `[r*TILE_ROWS*DATA_W +: TILE_ROWS*DATA_W]`.
- `tile_bx_o`, `tile_by_o`  out  8 each  block coordinates of the presented tile.
- `tile_last_o`  out  1  presented tile is the last of the pass.

## Operation
States: IDLE, FETCH, DRAIN, TILE, DONE, RELEASE.

- **IDLE:** if `data_prepare_i`=1, latch width, height and id.
  - A width or height of 0 is latched as 1.
  - Clear bx, by and row; go to FETCH.
- **FETCH:** assert `rd_en_o` for exactly TILE_ROWS consecutive cycles, row = 0..TILE_ROWS-1; then go to DRAIN.
- **Capture:** a shift register of length RD_LAT delays `rd_en_o` together with its row index. When its output is high, `rd_data_i` is written into the tile register at that row.
- **DRAIN:** wait until all TILE_ROWS rows are captured; then go to TILE.
- **TILE:** `tile_valid_o`=1, with data, bx, by and last held stable until `tile_ready_i`=1.
  - On acceptance, if the tile was the last one, go to DONE.
  - Otherwise advance in raster order (bx++; on bx = width-1, set bx=0 and by++), then go to FETCH.
- **DONE:** `loop_finished_o`=1 for one cycle; go to RELEASE.
- **RELEASE:** wait until `data_prepare_i`=0; then go to IDLE. This prevents a second pass on a stale prepare level.
- **Latched inputs:** command inputs are sampled only in IDLE. Changes to `data_prepare_i` or the size inputs mid-pass are ignored.
- **`tile_last_o`:** equals (bx==width-1 && by==height-1).
- **No prefetch:** no read is issued while in DRAIN, TILE, DONE or RELEASE.

## Timing
- **Reset (`reset`=0 at a clock edge):**
  - Next cycle: state=IDLE, all counters 0.
  - Every output 0, including `tile_data_o`, `rd_addr_o`, `tile_bx_o` and `tile_by_o`.
  - Mid-pass reset discards the pass; nothing is pulsed.
- **Tile latency:** prepare seen in IDLE at cycle P → FETCH cycles P+1..P+TILE_ROWS → `tile_valid_o` first high at P+TILE_ROWS+RD_LAT+1. With defaults: reads at P+1..P+6, valid at P+8.
- **Handshake:** a transfer occurs on any cycle where valid and ready are both 1. Ready may already be high when valid rises; the tile is accepted in that cycle.
- **Pass boundary:** acceptance of a non-last tile at cycle A → FETCH at A+1. With `tile_ready_i` held high, the tile period is TILE_ROWS+RD_LAT+1 cycles.
- **End of pass:** acceptance of the last tile at A → `loop_finished_o`=1 at A+1 only.
- **Main-controller cadence:** main drops prepare at A+2 (COMPLETE) and re-raises it at A+3.
  - RELEASE sees 0 at A+2 → IDLE at A+3.
  - The next pass is latched at A+3 with the new `data_id_i`.
- **Counter widths:** bx and by are 8 bits, row is 3 bits; no wrap occurs within a legal pass (width, height ≤ 255).

## Test plan
- **Single block:** width=1, height=1, id=3, ready held 1, prepare at P → six reads with addresses {3,0,0,0..5}; `tile_valid_o` at P+8 with the rows packed in order and `tile_last_o`=1; `loop_finished_o` at P+9 only.
- **Raster order:** width=2, height=3 → 36 reads; tiles presented in order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); `tile_last_o` high only on (1,2); exactly one finished pulse.
- **Backpressure:** `tile_ready_i`=0 for 5 cycles while valid → data, bx and by are stable; `rd_en_o`=0; the transfer occurs on the first ready cycle, and FETCH starts the next cycle.
- **Pass chaining:** drive prepare with the main-controller cadence (low one cycle after finished, high again with id=4) → second pass starts in the cycle after prepare returns high; addresses carry id 4. If prepare is held high through DONE, no restart occurs until a low is seen.
- **Reset mid-FETCH:** apply `reset`=0 during row 2 → all outputs 0 the next cycle. With prepare still high after release, the pass restarts at tile (0,0), row 0.
- **Zero size and RD_LAT:** width=0, height=0 with RD_LAT=3 → treated as one tile; valid first high at P+10.
